// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE-array sequencer: FSM encoding, precision
// mode constants and the result-latency derivation.
package pe_array_pkg;

    // Sequencer states, kept as plain 3-bit constants for legacy tools.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOADW = 3'd1;
    localparam logic [2:0] ST_WAITX = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Array precision select driven on mode_out.
    localparam logic MODE_8  = 1'b0;
    localparam logic MODE_16 = 1'b1;

    // Cycles from row_en[0] to the bottom-row registered result: the skew
    // down the column plus the bottom PE's own pipeline.
    function automatic int out_lat(input int rows, input int pe_lat);
        return rows - 1 + pe_lat;
    endfunction

endpackage

// File: rtl/pe_delay_line.sv
// DEPTH-stage 1-bit shift register with async active-low clear and a
// synchronous flush, used for row-enable skew and result-latency tracking.
module pe_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] taps_q;
    logic [DEPTH-1:0] taps_d;

    // Shift one stage per cycle, or flush the whole line on clr_i.
    always_comb begin
        // NOTE: assign a default first so every path drives taps_d and no latch is inferred.
        taps_d = taps_q;
        if (clr_i) begin
            taps_d = '0;
        end else begin
            taps_d    = taps_q << 1;
            taps_d[0] = d_i;
        end
    end

    // Register the shift state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every stage samples the pre-edge value of its neighbour.
        if (!rst_n) taps_q <= '0;
        else        taps_q <= taps_d;
    end

    assign q_o = taps_q[DEPTH-1];

endmodule

// File: rtl/pe_array_seq.sv
// Sequencer for a weight-stationary PE column: loads per-row weights,
// bursts a fully resident set of input vectors with skewed row enables,
// tracks result latency and reports completion.
module pe_array_seq
    import pe_array_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int PE_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             _res,
    input  logic             start,
    input  logic             reload_w,
    input  logic             mode_in,
    input  logic [CNT_W-1:0] n_vec,
    input  logic             abort,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [ROWS-1:0]  wrecv,
    input  logic [CNT_W:0]   x_count,
    output logic             x_rd,
    output logic [ROWS-1:0]  row_en,
    output logic             mode_out,
    output logic             res_valid,
    output logic             res_last,
    output logic             busy,
    output logic             done
);

    localparam int OUT_LAT = out_lat(ROWS, PE_LAT);
    localparam int PTR_W   = $clog2(ROWS);

    logic [2:0]       state_q,     state_d;
    logic [PTR_W-1:0] row_ptr_q,   row_ptr_d;
    logic [CNT_W-1:0] vec_total_q, vec_total_d;
    logic [CNT_W-1:0] vec_cnt_q,   vec_cnt_d;
    logic             mode_q,      mode_d;

    logic            run_en;
    logic            last_in;
    logic            w_hs;
    logic [ROWS-1:0] row_en_w;

    assign run_en  = (state_q == ST_RUN);
    assign last_in = run_en && (vec_cnt_q == vec_total_q - CNT_W'(1));
    assign w_hs    = (state_q == ST_LOADW) && w_valid;

    // Next-state and counter logic; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        vec_total_d = vec_total_q;
        vec_cnt_d   = vec_cnt_q;
        mode_d      = mode_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d      = mode_in;
                        vec_total_d = n_vec;
                        row_ptr_d   = '0;
                        vec_cnt_d   = '0;
                        state_d     = reload_w ? ST_LOADW : ST_WAITX;
                    end
                end
                ST_LOADW: begin
                    if (w_hs) begin
                        if (row_ptr_q == PTR_W'(ROWS - 1)) begin
                            row_ptr_d = '0;
                            state_d   = ST_WAITX;
                        end else begin
                            row_ptr_d = row_ptr_q + PTR_W'(1);
                        end
                    end
                end
                ST_WAITX: begin
                    // The array cannot stall, so the whole burst must be queued first.
                    if (vec_total_q == '0) begin
                        state_d = ST_DONE;
                    end else if (x_count >= {1'b0, vec_total_q}) begin
                        vec_cnt_d = '0;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_in) begin
                        vec_cnt_d = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        vec_cnt_d = vec_cnt_q + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (res_last) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge _res) begin
        if (!_res) begin
            state_q     <= ST_IDLE;
            row_ptr_q   <= '0;
            vec_total_q <= '0;
            vec_cnt_q   <= '0;
            mode_q      <= MODE_8;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            vec_total_q <= vec_total_d;
            vec_cnt_q   <= vec_cnt_d;
            mode_q      <= mode_d;
        end
    end

    // Row skew: each row's enable is the row above delayed one cycle.
    assign row_en_w[0] = run_en;
    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        pe_delay_line #(.DEPTH(1)) u_skew (
            .clk   (clk),
            .rst_n (_res),
            .clr_i (abort),
            .d_i   (row_en_w[r-1]),
            .q_o   (row_en_w[r])
        );
    end

    // Bottom row's enable plus its PE pipeline gives the result strobe.
    pe_delay_line #(.DEPTH(PE_LAT)) u_valid (
        .clk   (clk),
        .rst_n (_res),
        .clr_i (abort),
        .d_i   (row_en_w[ROWS-1]),
        .q_o   (res_valid)
    );

    // Final-vector marker travels the full result latency alongside it.
    pe_delay_line #(.DEPTH(OUT_LAT)) u_last (
        .clk   (clk),
        .rst_n (_res),
        .clr_i (abort),
        .d_i   (last_in),
        .q_o   (res_last)
    );

    assign row_en   = row_en_w;
    assign w_ready  = (state_q == ST_LOADW);
    assign wrecv    = w_hs ? (ROWS'(1) << row_ptr_q) : '0;
    assign x_rd     = run_en;
    assign mode_out = mode_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: doc/pe_array_seq.md
Name: pe_array_seq

Overview:
- Sequencer for a ROWS-deep column stack of 16/8-bit PE cells (the weight-stationary systolic MAC array).
- Loads one weight per row via per-row weight-receive strobes, then bursts N input vectors through the array with per-row skewed enables.
- Tracks pipeline latency, flags the bottom-of-column results valid, and reports done.
- Sits between the AXI-side register/FIFO logic and the PE array; owns array mode switching, which occurs only in IDLE.

Parameters:
ROWS, 4, number of PE rows in the column (≥2)
PE_LAT, 2, cycles from row enable to that PE's registered accumulator output
CNT_W, 16, width of the vector count

Ports:
clk  in  1  system clock; all state updates on rising edge
_res  in  1  reset, asynchronous, active-low
start  in  1  begin a job; sampled only in IDLE
reload_w  in  1  with start: 1 = load new weights first, 0 = reuse held weights
mode_in  in  1  array precision (1 = 16-bit, 0 = 8-bit); latched at start
n_vec  in  CNT_W  number of input vectors in the job
abort  in  1  synchronous abort, any state
w_valid  in  1  weight FIFO has data
w_ready  out  1  weight consumed this cycle when w_valid & w_ready
wrecv  out  ROWS  one-hot weight-receive strobes to the PE rows
x_count  in  CNT_W+1  vectors currently available in the input FIFO
x_rd  out  1  pop one input vector (one per cycle)
row_en  out  ROWS  per-row PE enable, skewed by one cycle per row
mode_out  out  1  latched mode to the array
res_valid  out  1  bottom-row result valid this cycle
res_last  out  1  final result of the job (qualifies res_valid)
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (_res low, async): state IDLE; all outputs 0, including mode_out; counters and skew/latency shift registers cleared.
- FSM states: IDLE, LOADW, WAITX, RUN, DRAIN, DONE.
- IDLE, start=1:
  - Latch mode_in→mode_out, n_vec→vec_total.
  - Next state LOADW if reload_w=1, else WAITX.
  - start is ignored outside IDLE.
- LOADW:
  - w_ready=1; row_ptr starts at 0.
  - wrecv = onehot(row_ptr) gated by w_valid (combinational from the registered row_ptr).
  - row_ptr increments on each handshake; after handshake ROWS-1, go to WAITX.
  - w_valid low stalls the load with no timeout.
- WAITX:
  - If vec_total=0, go to DONE.
  - Else, once x_count ≥ vec_total, go to RUN.
  - The whole burst must be resident because the PE array has no stall.
- RUN:
  - x_rd=1 and row_en[0]=1 for exactly vec_total cycles, counted by vec_cnt.
  - Then go to DRAIN.
- Skew and result timing:
  - row_en[r] is row_en[0] delayed r cycles through a register chain.
  - res_valid is row_en[0] delayed OUT_LAT = ROWS-1+PE_LAT cycles.
  - res_last marks the res_valid cycle for the final vector.
- DRAIN: wait until res_last has issued, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy: 1 in every state except IDLE; includes the DONE cycle.
- Sink: has no backpressure and must accept every res_valid cycle.
- abort:
  - Next state IDLE; row_en chain, res_valid chain, x_rd, w_ready and wrecv all forced 0 the following cycle.
  - No done pulse; held weights in the array are undefined after an aborted LOADW.
- abort and start in the same IDLE cycle: abort wins.
- Counter width: vec_cnt compares against vec_total with CNT_W bits; n_vec=2^CNT_W-1 is legal; no wrap.
- mode_out changes only on the IDLE→start transition, never mid-job.

Decomposition:
- Shared package pe_array_pkg:
  - FSM state encoding (3-bit localparams).
  - MODE_8 / MODE_16 constants.
  - OUT_LAT derivation function.
- One natural sub-module, pe_delay_line: a DEPTH-parameterised 1-bit shift register with async active-low clear.
  - Used for the row_en skew taps and for the res_valid/res_last latency chain.

Test Plan:
- Reset mid-RUN (ROWS=4, n_vec=5, assert _res at RUN cycle 2) → all outputs 0 immediately, no done; a following start behaves normally.
- Weight load with stalls: reload_w=1, w_valid toggled 1,0,1,1,0,1 → wrecv=0001,0010,0100,1000 on valid cycles only, then WAITX; 4 handshakes total.
- Burst timing (ROWS=4, PE_LAT=2, n_vec=3, x_count=3, reload_w=0, RUN starts cycle c0):
  - x_rd high c0..c2; row_en[3] high c3..c5.
  - res_valid high c5..c7, res_last at c7.
  - done at c8; busy low at c9.
- Insufficient input: n_vec=6, x_count rises 2→5→6 → stays in WAITX until x_count=6, then x_rd for exactly 6 cycles.
- n_vec=0 with reload_w=1 → 4 weight handshakes, then done; x_rd and row_en never assert.
- Abort during DRAIN (n_vec=4, abort 1 cycle after RUN ends) → res_valid 0 next cycle, no done, IDLE; mode_out changes only on the next start.
